hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_fwd_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU definitions for the hazard controller: FSM state encoding,
// forwarding-select codes and the forwarding priority helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_WAIT  = 2'b11
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // The youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] exmem_rd,
    input logic       exmem_we,
    input logic [4:0] memwb_rd,
    input logic       memwb_we
  );
    logic [1:0] sel;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational operand forwarding for the two EX-stage source registers.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Pick the forwarding source independently for rs1 and rs2.
  always_comb begin
    fwd_a = fwd_sel(idex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    fwd_b = fwd_sel(idex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use
// stall, operand forwarding, saturating event counters and a WAIT watchdog.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  input  logic [4:0]       idex_rs1_i,
  input  logic [4:0]       idex_rs2_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic             exmem_regwrite_i,
  input  logic [4:0]       memwb_rd_i,
  input  logic             memwb_regwrite_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output logic             err_o
);

  // Watchdog wide enough to hold TIMEOUT+1, where it saturates.
  localparam int WD_W = $clog2(TIMEOUT + 2);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  state_t          next_state;
  logic            mem_wait;
  logic            load_use;
  logic            ev_stall;
  logic            ev_flush;
  logic            ev_wait;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [WD_W-1:0] wd_cnt;
  logic            err;

  fwd_unit u_fwd (
    .idex_rs1       (idex_rs1_i),
    .idex_rs2       (idex_rs2_i),
    .exmem_rd       (exmem_rd_i),
    .exmem_regwrite (exmem_regwrite_i),
    .memwb_rd       (memwb_rd_i),
    .memwb_regwrite (memwb_regwrite_i),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // Raw hazard conditions; x0 never creates a load-use dependency.
  always_comb begin
    mem_wait = dmem_req_i & ~dmem_ready_i;
    load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
               (((idex_rd_i == ifid_rs1_i) && use_rs1_i) ||
                ((idex_rd_i == ifid_rs2_i) && use_rs2_i));
  end

  // Prioritised event decode: wait > branch > load-use > run; reset forces defaults.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    fwd_a_o        = FWD_RF;
    fwd_b_o        = FWD_RF;
    ev_stall       = 1'b0;
    ev_flush       = 1'b0;
    ev_wait        = 1'b0;
    next_state     = ST_RUN;
    if (!rst_i) begin
      next_state = ST_RUN;
    end else begin
      fwd_a_o = fwd_a;
      fwd_b_o = fwd_b;
      if (mem_wait) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_write_o  = 1'b0;
        memwb_bubble_o = 1'b1;
        ev_wait        = 1'b1;
        next_state     = ST_WAIT;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        ev_flush     = 1'b1;
        next_state   = ST_FLUSH;
      end else if (load_use && (state != ST_FLUSH)) begin
        // ID/EX holds a bubble right after a flush, so the match is stale there.
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
        ev_stall     = 1'b1;
        next_state   = ST_STALL;
      end else begin
        next_state = ST_RUN;
      end
    end
  end

  // State register, saturating counters, watchdog and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_RUN;
      stall_cnt_o <= {CNT_W{1'b0}};
      flush_cnt_o <= {CNT_W{1'b0}};
      wait_cnt_o  <= {CNT_W{1'b0}};
      wd_cnt      <= {WD_W{1'b0}};
      err         <= 1'b0;
    end else begin
      state <= next_state;
      if (ev_stall && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (ev_flush && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
      if (ev_wait && (wait_cnt_o != CNT_MAX)) begin
        wait_cnt_o <= wait_cnt_o + CNT_W'(1);
      end
      if (ev_wait) begin
        if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
        // This cycle takes the consecutive-wait count past TIMEOUT.
        if (wd_cnt >= WD_LIM) begin
          err <= 1'b1;
        end
      end else begin
        wd_cnt <= {WD_W{1'b0}};
      end
    end
  end

  assign err_o = err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W = 4, TIMEOUT = 3).
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam logic [6:0] C_RUN = 7'b1111000;
  localparam logic [6:0] C_STL = 7'b0011010;
  localparam logic [6:0] C_FL  = 7'b1111110;
  localparam logic [6:0] C_WT  = 7'b0000001;

  typedef struct {
    logic       rst;
    logic [4:0] ifid_rs1, ifid_rs2;
    logic       use1, use2;
    logic [4:0] idex_rs1, idex_rs2, idex_rd;
    logic       memread, br;
    logic [4:0] exmem_rd;
    logic       exmem_we;
    logic [4:0] memwb_rd;
    logic       memwb_we;
    logic       req, rdy;
  } in_t;

  typedef struct {
    string      nm;
    logic [6:0] ctrl;
    logic [1:0] fa, fb;
    int         s, f, w;
    logic       e;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, use_rs1_i, use_rs2_i, idex_memread_i, branch_taken_i;
  logic exmem_regwrite_i, memwb_regwrite_i, dmem_req_i, dmem_ready_i;
  logic [4:0] ifid_rs1_i, ifid_rs2_i, idex_rs1_i, idex_rs2_i, idex_rd_i, exmem_rd_i, memwb_rd_i;
  logic pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
  logic ifid_flush_o, idex_flush_o, memwb_bubble_o, err_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW), .TIMEOUT(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
    .idex_rs1_i(idex_rs1_i), .idex_rs2_i(idex_rs2_i), .idex_rd_i(idex_rd_i),
    .idex_memread_i(idex_memread_i), .branch_taken_i(branch_taken_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_write_o(idex_write_o), .exmem_write_o(exmem_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .memwb_bubble_o(memwb_bubble_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .wait_cnt_o(wait_cnt_o),
    .err_o(err_o)
  );

  function automatic in_t idle();
    in_t t;
    t = '{default: '0};
    t.rst = 1'b1;
    return t;
  endfunction

  function automatic in_t lu(input in_t t);
    t.memread = 1'b1;
    t.idex_rd = 5'd5;
    t.ifid_rs1 = 5'd5;
    t.use1 = 1'b1;
    return t;
  endfunction

  function automatic in_t br(input in_t t);
    t.br = 1'b1;
    return t;
  endfunction

  function automatic in_t mw(input in_t t, input logic rdy);
    t.req = 1'b1;
    t.rdy = rdy;
    return t;
  endfunction

  function automatic in_t rs(input in_t t);
    t.rst = 1'b0;
    return t;
  endfunction

  function automatic in_t fw(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] erd,
                             input logic ewe, input logic [4:0] mrd, input logic mwe);
    in_t t;
    t = idle();
    t.idex_rs1 = rs1;
    t.idex_rs2 = rs2;
    t.exmem_rd = erd;
    t.exmem_we = ewe;
    t.memwb_rd = mrd;
    t.memwb_we = mwe;
    return t;
  endfunction

  task automatic add(input string nm, input in_t i, input logic [6:0] c, input logic [1:0] fa,
                     input logic [1:0] fb, input int s, input int f, input int w, input logic e);
    vec_t v;
    v.i = i;
    v.e = '{nm: nm, ctrl: c, fa: fa, fb: fb, s: s, f: f, w: w, e: e};
    vecs.push_back(v);
  endtask

  task automatic apply(input in_t t);
    rst_i = t.rst;
    ifid_rs1_i = t.ifid_rs1;
    ifid_rs2_i = t.ifid_rs2;
    use_rs1_i = t.use1;
    use_rs2_i = t.use2;
    idex_rs1_i = t.idex_rs1;
    idex_rs2_i = t.idex_rs2;
    idex_rd_i = t.idex_rd;
    idex_memread_i = t.memread;
    branch_taken_i = t.br;
    exmem_rd_i = t.exmem_rd;
    exmem_regwrite_i = t.exmem_we;
    memwb_rd_i = t.memwb_rd;
    memwb_regwrite_i = t.memwb_we;
    dmem_req_i = t.req;
    dmem_ready_i = t.rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  // Drive one cycle: inputs after the rising edge, expectation onto the scoreboard.
  task automatic drive(input in_t i, input exp_t e);
    @(posedge clk);
    #1;
    apply(i);
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the settled DUT outputs.
  task automatic collect();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 want 1");
    end else begin
      e = sb.pop_front();
      chk({e.nm, ".ctrl"}, 32'({pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
                               ifid_flush_o, idex_flush_o, memwb_bubble_o}), 32'(e.ctrl));
      chk({e.nm, ".fwd_a"}, 32'(fwd_a_o), 32'(e.fa));
      chk({e.nm, ".fwd_b"}, 32'(fwd_b_o), 32'(e.fb));
      chk({e.nm, ".stall_cnt"}, 32'(stall_cnt_o), e.s);
      chk({e.nm, ".flush_cnt"}, 32'(flush_cnt_o), e.f);
      chk({e.nm, ".wait_cnt"}, 32'(wait_cnt_o), e.w);
      chk({e.nm, ".err"}, 32'(err_o), 32'(e.e));
    end
  endtask

  initial begin
    in_t hot;
    in_t t;
    exp_t e;
    apply(rs(idle()));

    hot = mw(br(lu(fw(5'd3, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1))), 1'b0);
    add("reset_hot0", rs(hot), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("reset_hot1", rs(hot), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("run_idle",   idle(),  C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("fwd_exmem",  fw(5'd3, 5'd7, 5'd3, 1'b1, 5'd3, 1'b1), C_RUN, 2'b10, 2'b00, 0, 0, 0, 1'b0);
    add("fwd_memwb",  fw(5'd3, 5'd7, 5'd0, 1'b1, 5'd3, 1'b1), C_RUN, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    add("fwd_x0",     fw(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("fwd_nowe",   fw(5'd3, 5'd7, 5'd3, 1'b0, 5'd3, 1'b1), C_RUN, 2'b01, 2'b00, 0, 0, 0, 1'b0);
    add("fwd_both",   fw(5'd9, 5'd9, 5'd9, 1'b1, 5'd4, 1'b1), C_RUN, 2'b10, 2'b10, 0, 0, 0, 1'b0);
    add("fwd_b_nowe", fw(5'd1, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    t = idle(); t.rdy = 1'b0;
    add("ready_noreq", t, C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("lu_stall",   lu(idle()), C_STL, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    t = lu(idle()); t.memread = 1'b0;
    add("lu_bubble",  t, C_RUN, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    t = lu(idle()); t.use1 = 1'b0;
    add("lu_nouse",   t, C_RUN, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    t = lu(idle()); t.ifid_rs1 = 5'd0; t.use1 = 1'b0; t.ifid_rs2 = 5'd5; t.use2 = 1'b1;
    add("lu_rs2",     t, C_STL, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    add("after_rs2",  idle(), C_RUN, 2'b00, 2'b00, 2, 0, 0, 1'b0);
    t = lu(idle()); t.idex_rd = 5'd0; t.ifid_rs1 = 5'd0;
    add("lu_x0",      t, C_RUN, 2'b00, 2'b00, 2, 0, 0, 1'b0);
    add("rst_a",      rs(idle()), C_RUN, 2'b00, 2'b00, 2, 0, 0, 1'b0);
    add("br_and_lu",  br(lu(idle())), C_FL, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("flush_mask", lu(idle()), C_RUN, 2'b00, 2'b00, 0, 1, 0, 1'b0);
    add("mask_1cyc",  lu(idle()), C_STL, 2'b00, 2'b00, 0, 1, 0, 1'b0);
    add("after_mask", idle(), C_RUN, 2'b00, 2'b00, 1, 1, 0, 1'b0);
    add("br_1",       br(idle()), C_FL, 2'b00, 2'b00, 1, 1, 0, 1'b0);
    add("br_2",       br(idle()), C_FL, 2'b00, 2'b00, 1, 2, 0, 1'b0);
    add("after_br",   idle(), C_RUN, 2'b00, 2'b00, 1, 3, 0, 1'b0);
    add("rst_b",      rs(idle()), C_RUN, 2'b00, 2'b00, 1, 3, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add($sformatf("wait_br%0d", k), mw(br(idle()), 1'b0), C_WT, 2'b00, 2'b00, 0, 0, k, 1'b0);
    end
    add("ready_br",   mw(br(idle()), 1'b1), C_FL, 2'b00, 2'b00, 0, 0, 4, 1'b1);
    add("after_wbr",  idle(), C_RUN, 2'b00, 2'b00, 0, 1, 4, 1'b1);
    add("rst_c",      rs(idle()), C_RUN, 2'b00, 2'b00, 0, 1, 4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      add($sformatf("wd%0d", k), mw(idle(), 1'b0), C_WT, 2'b00, 2'b00, 0, 0, k, (k == 4) ? 1'b1 : 1'b0);
    end
    add("wd_ready",   mw(idle(), 1'b1), C_RUN, 2'b00, 2'b00, 0, 0, 5, 1'b1);
    add("wd_sticky",  idle(), C_RUN, 2'b00, 2'b00, 0, 0, 5, 1'b1);
    add("rst_d",      rs(idle()), C_RUN, 2'b00, 2'b00, 0, 0, 5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      add($sformatf("wdc_a%0d", k), mw(idle(), 1'b0), C_WT, 2'b00, 2'b00, 0, 0, k, 1'b0);
    end
    add("wdc_gap",    mw(idle(), 1'b1), C_RUN, 2'b00, 2'b00, 0, 0, 3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add($sformatf("wdc_b%0d", k), mw(idle(), 1'b0), C_WT, 2'b00, 2'b00, 0, 0, 3 + k, 1'b0);
    end
    add("wdc_end",    mw(idle(), 1'b1), C_RUN, 2'b00, 2'b00, 0, 0, 6, 1'b0);
    add("midwait",    mw(idle(), 1'b0), C_WT, 2'b00, 2'b00, 0, 0, 6, 1'b0);
    add("midwait_rst", rs(mw(idle(), 1'b0)), C_RUN, 2'b00, 2'b00, 0, 0, 7, 1'b0);
    add("midwait_out", idle(), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("midstall",   lu(idle()), C_STL, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    add("midstall_rst", rs(lu(idle())), C_RUN, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    add("midstall_out", idle(), C_RUN, 2'b00, 2'b00, 0, 0, 0, 1'b0);

    foreach (vecs[n]) begin
      drive(vecs[n].i, vecs[n].e);
      collect();
    end

    // Saturation: 20 back-to-back load-use stalls on a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      e = '{nm: $sformatf("sat%0d", k), ctrl: C_STL, fa: 2'b00, fb: 2'b00,
            s: (k < 15) ? k : 15, f: 0, w: 0, e: 1'b0};
      drive(lu(idle()), e);
      collect();
    end
    e = '{nm: "sat_hold", ctrl: C_RUN, fa: 2'b00, fb: 2'b00, s: 15, f: 0, w: 0, e: 1'b0};
    drive(idle(), e);
    collect();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
